// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues req/ack reads to instruction
// memory and hands instructions to decode with a valid/stall handshake.
module fetch_unit #(
    parameter int MIPS_PC_WIDTH_m1 = 7,
    parameter int INSTR_WIDTH_m1   = 7
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [MIPS_PC_WIDTH_m1:0] next_pc,
    input  logic                      flush,
    input  logic [MIPS_PC_WIDTH_m1:0] flush_pc,
    input  logic                      stall,
    input  logic                      imem_ack,
    input  logic [INSTR_WIDTH_m1:0]   imem_data,
    output logic                      imem_req,
    output logic [MIPS_PC_WIDTH_m1:0] imem_addr,
    output logic [MIPS_PC_WIDTH_m1:0] curr_pc,
    output logic [INSTR_WIDTH_m1:0]   instr,
    output logic                      instr_valid
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WAIT  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_HOLD  = 2'd3;

    logic [1:0]                state_q, state_d;
    logic [MIPS_PC_WIDTH_m1:0] pc_q, pc_d;
    logic [MIPS_PC_WIDTH_m1:0] addr_q, addr_d;
    logic [INSTR_WIDTH_m1:0]   instr_q, instr_d;
    logic                      valid_q, valid_d;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        addr_d  = addr_q;
        instr_d = instr_q;
        valid_d = valid_q;
        case (state_q)
            S_IDLE: begin
                state_d = S_WAIT;
                if (flush) begin
                    pc_d   = flush_pc;
                    addr_d = flush_pc;
                end else begin
                    addr_d = pc_q;
                end
            end
            S_WAIT: begin
                if (imem_ack) begin
                    if (flush) begin
                        pc_d   = flush_pc;
                        addr_d = flush_pc;
                    end else begin
                        instr_d = imem_data;
                        valid_d = 1'b1;
                        state_d = S_HOLD;
                    end
                end else if (flush) begin
                    // addr_q must stay put until the stale read completes
                    pc_d    = flush_pc;
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (flush) pc_d = flush_pc;
                if (imem_ack) begin
                    addr_d  = flush ? flush_pc : pc_q;
                    state_d = S_WAIT;
                end
            end
            S_HOLD: begin
                if (flush) begin
                    pc_d    = flush_pc;
                    addr_d  = flush_pc;
                    valid_d = 1'b0;
                    state_d = S_WAIT;
                end else if (!stall) begin
                    pc_d    = next_pc;
                    addr_d  = next_pc;
                    valid_d = 1'b0;
                    state_d = S_WAIT;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            addr_q  <= '0;
            instr_q <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            addr_q  <= addr_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
        end
    end

    assign imem_req    = (state_q == S_WAIT) || (state_q == S_DRAIN);
    assign imem_addr   = addr_q;
    assign curr_pc     = pc_q;
    assign instr       = instr_q;
    assign instr_valid = valid_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboarded bench for fetch_unit: a latency-programmable memory model
// answers reads, and every instruction reaching decode is checked in order.
module tb_fetch_unit;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] next_pc;
    logic       flush = 1'b0;
    logic [7:0] flush_pc = '0;
    logic       stall = 1'b1;
    logic       imem_ack = 1'b0;
    logic [7:0] imem_data = '0;
    logic       imem_req;
    logic [7:0] imem_addr;
    logic [7:0] curr_pc;
    logic [7:0] instr;
    logic       instr_valid;

    int         n_cmp = 0;
    int         n_err = 0;
    int         lat = 0;
    int         cnt = 0;
    logic       np_ovr = 1'b1;
    logic [7:0] np_val = 8'h10;
    logic       prev_v = 1'b0;
    logic [15:0] exp_q[$];

    always #5 clk = ~clk;

    // external next-PC logic: increment with natural 8-bit wrap, or a fixed target
    assign next_pc = np_ovr ? np_val : 8'(curr_pc + 8'd1);

    fetch_unit dut (
        .clk(clk), .reset(reset), .next_pc(next_pc), .flush(flush),
        .flush_pc(flush_pc), .stall(stall), .imem_ack(imem_ack),
        .imem_data(imem_data), .imem_req(imem_req), .imem_addr(imem_addr),
        .curr_pc(curr_pc), .instr(instr), .instr_valid(instr_valid)
    );

    function automatic logic [7:0] mem_word(input logic [7:0] a);
        return a ^ 8'hA5;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic push(input logic [7:0] a);
        exp_q.push_back({a, mem_word(a)});
    endtask

    task automatic wait_valid(input string tag);
        for (int i = 0; i < 30 && !instr_valid; i++) step();
        chk(tag, instr_valid, 1);
    endtask

    // memory: acks once a transfer has been outstanding for lat cycles
    always @(negedge clk) begin
        if (imem_req) begin
            if (cnt >= lat) begin
                imem_ack  = 1'b1;
                imem_data = mem_word(imem_addr);
                cnt       = 0;
            end else begin
                imem_ack = 1'b0;
                cnt++;
            end
        end else begin
            imem_ack = 1'b0;
            cnt      = 0;
        end
    end

    // each rising edge of instr_valid is a new instruction delivered to decode
    always @(negedge clk) begin
        if (instr_valid && !prev_v) begin
            if (exp_q.size() == 0) begin
                chk("sb_unexpected", exp_q.size(), 1);
            end else begin
                logic [15:0] e;
                e = exp_q.pop_front();
                chk("sb_pc", curr_pc, e[15:8]);
                chk("sb_instr", instr, e[7:0]);
            end
        end
        prev_v = instr_valid;
    end

    initial begin
        // reset and first fetch
        step(); step();
        chk("rst_req", imem_req, 0);
        chk("rst_valid", instr_valid, 0);
        chk("rst_pc", curr_pc, 0);
        chk("rst_addr", imem_addr, 0);
        chk("rst_instr", instr, 0);
        push(8'h00);
        reset = 1'b0;
        step();
        chk("first_req", imem_req, 1);
        chk("first_addr", imem_addr, 0);
        chk("first_nv", instr_valid, 0);
        step();
        chk("first_valid", instr_valid, 1);
        chk("first_instr", instr, 8'hA5);
        chk("first_pc", curr_pc, 0);

        // stall hold
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_instr", instr, 8'hA5);
            chk("stall_pc", curr_pc, 0);
            chk("stall_valid", instr_valid, 1);
            chk("stall_req", imem_req, 0);
        end
        stall = 1'b0;
        push(8'h10);
        step();
        stall = 1'b1;
        chk("unstall_req", imem_req, 1);
        chk("unstall_addr", imem_addr, 8'h10);
        chk("unstall_pc", curr_pc, 8'h10);
        wait_valid("unstall_tmo");

        // sequential flow with wrap, entered through a flush in HOLD
        np_ovr = 1'b0;
        stall = 1'b0;
        flush = 1'b1;
        flush_pc = 8'hFE;
        foreach (exp_q[i]) ;
        push(8'hFE); push(8'hFF); push(8'h00); push(8'h01);
        step();
        flush = 1'b0;
        for (int i = 0; i < 4; i++) begin
            logic [7:0] a;
            a = 8'(8'hFE + i);
            chk("seq_req", imem_req, 1);
            chk("seq_addr", imem_addr, a);
            chk("seq_pc", curr_pc, a);
            step();
            chk("seq_valid", instr_valid, 1);
            if (i == 3) stall = 1'b1;
            step();
        end
        chk("seq_park", curr_pc, 8'h01);

        // flush during WAIT with a slow memory
        lat = 3;
        flush = 1'b1;
        flush_pc = 8'h20;
        step();
        flush_pc = 8'h40;
        chk("fw_addr0", imem_addr, 8'h20);
        step();
        flush = 1'b0;
        chk("fw_addr1", imem_addr, 8'h20);
        chk("fw_pc", curr_pc, 8'h40);
        chk("fw_nv", instr_valid, 0);
        chk("fw_req", imem_req, 1);
        step();
        chk("fw_addr2", imem_addr, 8'h20);
        step();
        chk("fw_addr3", imem_addr, 8'h20);
        push(8'h40);
        step();
        chk("fw_redir", imem_addr, 8'h40);
        lat = 0;
        wait_valid("fw_tmo");

        // flush coincident with ack in WAIT
        flush = 1'b1;
        flush_pc = 8'h70;
        step();
        flush_pc = 8'h80;
        step();
        flush = 1'b0;
        chk("fa_addr", imem_addr, 8'h80);
        chk("fa_pc", curr_pc, 8'h80);
        chk("fa_nv", instr_valid, 0);
        push(8'h80);
        wait_valid("fa_tmo");

        // flush and stall together in HOLD
        flush = 1'b1;
        flush_pc = 8'h90;
        step();
        flush = 1'b0;
        chk("fs_nv", instr_valid, 0);
        chk("fs_addr", imem_addr, 8'h90);
        chk("fs_req", imem_req, 1);
        push(8'h90);
        wait_valid("fs_tmo");

        // double flush while draining
        lat = 4;
        flush = 1'b1;
        flush_pc = 8'hA0;
        step();
        flush_pc = 8'h50;
        step();
        flush_pc = 8'h60;
        step();
        flush = 1'b0;
        chk("df_pc", curr_pc, 8'h60);
        chk("df_addr", imem_addr, 8'hA0);
        push(8'h60);
        for (int i = 0; i < 10 && imem_addr == 8'hA0; i++) step();
        chk("df_redir", imem_addr, 8'h60);
        wait_valid("df_tmo");

        // flush on the ack edge of a draining read
        lat = 2;
        flush = 1'b1;
        flush_pc = 8'hB0;
        step();
        flush_pc = 8'hC0;
        step();
        flush = 1'b0;
        step();
        flush = 1'b1;
        flush_pc = 8'hD0;
        step();
        flush = 1'b0;
        chk("dc_addr", imem_addr, 8'hD0);
        chk("dc_pc", curr_pc, 8'hD0);
        push(8'hD0);
        lat = 0;
        wait_valid("dc_tmo");

        // asynchronous reset mid-WAIT
        lat = 5;
        flush = 1'b1;
        flush_pc = 8'hE0;
        step();
        flush = 1'b0;
        chk("ar_pre_req", imem_req, 1);
        #2 reset = 1'b1;
        #1;
        chk("ar_req", imem_req, 0);
        chk("ar_valid", instr_valid, 0);
        chk("ar_pc", curr_pc, 0);
        step();
        lat = 0;
        push(8'h00);
        reset = 1'b0;
        wait_valid("ar_tmo");
        step();

        chk("sb_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
